// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// mem_access_if : data-memory request/acknowledge bus of the MEM stage
// Rev 1.0
// ============================================================================
interface mem_access_if;
  logic        data_req_o;
  logic        data_we_o;
  logic [31:0] data_addr_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_ack_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_we_o, data_addr_o, data_be_o, data_wdata_o,
    input  data_ack_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_addr_o, data_be_o, data_wdata_o,
    output data_ack_i, data_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// mem_access : MEM stage, passes ALU results and runs byte/half/word bus accesses
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned LH/SH/LW/SW without a bus cycle.
// Rev 1.0
// ============================================================================
module mem_access #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   aluop_i,
  input  logic [31:0]  mem_addr_i,
  input  logic [31:0]  reg2_i,
  input  logic [4:0]   wd_i,
  input  logic         wreg_i,
  input  logic [31:0]  wdata_i,
  output logic [4:0]   wd_o,
  output logic         wreg_o,
  output logic [31:0]  wdata_o,
  output logic         stallreq,
  mem_access_if.master bus,
  output logic         bus_err_o
);

  localparam logic [7:0] OP_LB = 8'hE0;
  localparam logic [7:0] OP_LH = 8'hE1;
  localparam logic [7:0] OP_LW = 8'hE3;
  localparam logic [7:0] OP_SB = 8'hE8;
  localparam logic [7:0] OP_SH = 8'hE9;
  localparam logic [7:0] OP_SW = 8'hEB;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      load_data;
  logic [31:0]      ext_data;
  logic [31:0]      store_data;
  logic [3:0]       be_nxt;
  logic [1:0]       lane;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  logic             err;
  logic             issue;
  logic             misaligned;
  logic             is_lb, is_lh, is_lw, is_sb, is_sh, is_sw;
  logic             is_load, is_store, is_mem;

  assign is_lb    = (aluop_i == OP_LB);
  assign is_lh    = (aluop_i == OP_LH);
  assign is_lw    = (aluop_i == OP_LW);
  assign is_sb    = (aluop_i == OP_SB);
  assign is_sh    = (aluop_i == OP_SH);
  assign is_sw    = (aluop_i == OP_SW);
  assign is_load  = is_lb | is_lh | is_lw;
  assign is_store = is_sb | is_sh | is_sw;
  assign is_mem   = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((is_lh | is_sh) & mem_addr_i[0]) |
                      ((is_lw | is_sw) & (mem_addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Little-endian lane selection and store-data replication
  always_comb begin
    be_nxt     = 4'b1111;
    store_data = reg2_i;
    if (is_lb | is_sb) begin
      be_nxt     = 4'b0001 << mem_addr_i[1:0];
      store_data = {4{reg2_i[7:0]}};
    end else if (is_lh | is_sh) begin
      be_nxt     = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      store_data = {2{reg2_i[15:0]}};
    end
  end

  always_comb begin
    case (lane)
      2'd0:    rbyte = bus.data_rdata_i[7:0];
      2'd1:    rbyte = bus.data_rdata_i[15:8];
      2'd2:    rbyte = bus.data_rdata_i[23:16];
      default: rbyte = bus.data_rdata_i[31:24];
    endcase
    rhalf    = lane[1] ? bus.data_rdata_i[31:16] : bus.data_rdata_i[15:0];
    ext_data = bus.data_rdata_i;
    if (is_lb)
      ext_data = {{24{rbyte[7]}}, rbyte};
    else if (is_lh)
      ext_data = {{16{rhalf[15]}}, rhalf};
  end

  assign bus.data_req_o = (state == S_BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stallreq  = 1'b0;
    wd_o      = wd_i;
    wreg_o    = 1'b0;
    wdata_o   = 32'h0;
    bus_err_o = 1'b0;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_mem) begin
          stallreq = 1'b1;
          if (misaligned) begin
            bus_err_o = 1'b1;
            state_nxt = S_DONE;
          end else begin
            issue     = 1'b1;
            state_nxt = S_BUSY;
          end
        end else begin
          wreg_o  = wreg_i;
          wdata_o = wdata_i;
        end
      end
      S_BUSY: begin
        stallreq = 1'b1;
        // An ack coinciding with the last allowed cycle wins over the timeout
        if (bus.data_ack_i) begin
          state_nxt = S_DONE;
        end else if (cnt == TIMEOUT_LAST) begin
          bus_err_o = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        wreg_o    = (is_load && !err) ? wreg_i : 1'b0;
        wdata_o   = is_load ? load_data : 32'h0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!rst) begin
      wd_o      = 5'd0;
      wreg_o    = 1'b0;
      wdata_o   = 32'h0;
      stallreq  = 1'b0;
      bus_err_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt              <= '0;
      load_data        <= 32'h0;
      err              <= 1'b0;
      lane             <= 2'd0;
      bus.data_we_o    <= 1'b0;
      bus.data_addr_o  <= 32'h0;
      bus.data_be_o    <= 4'h0;
      bus.data_wdata_o <= 32'h0;
    end else begin
      cnt <= (state == S_BUSY) ? cnt + 1'b1 : '0;
      if (state != S_DONE)
        err <= bus_err_o;
      // Cleared on every IDLE cycle so an aborted load returns zero
      if (state == S_IDLE)
        load_data <= 32'h0;
      else if (state == S_BUSY && bus.data_ack_i)
        load_data <= ext_data;
      if (issue) begin
        lane             <= mem_addr_i[1:0];
        bus.data_we_o    <= is_store;
        bus.data_addr_o  <= {mem_addr_i[31:2], 2'b00};
        bus.data_be_o    <= be_nxt;
        bus.data_wdata_o <= store_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// tb_mem_access : directed + randomized bench with a behavioural MEM-stage model
// Rev 1.0
// ============================================================================
module tb_mem_access;

  localparam int ACK_TIMEOUT = 16;
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_ORI = 8'h25;
  localparam logic [7:0] OP_NOP = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  aluop;
  logic [31:0] mem_addr, reg2, wdata;
  logic [4:0]  wd;
  logic        wreg;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_if bus ();

  mem_access #(.ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .mem_addr_i (mem_addr),
    .reg2_i     (reg2),
    .wd_i       (wd),
    .wreg_i     (wreg),
    .wdata_i    (wdata),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .stallreq   (stallreq),
    .bus        (bus),
    .bus_err_o  (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one op and follows it until the stage releases, comparing with the model
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                        input logic [31:0] wdat, input logic [31:0] rdata,
                        input logic [4:0] wdst, input logic wen, input int waits);
    bit          is_load, is_store, is_mem, misal, exp_err, done;
    int          busy_cycles, exp_stall, stall, reqc, errc, cyc;
    byte         b8;
    shortint     h16;
    logic [31:0] exp_ext, exp_bw, exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_wreg;

    is_load  = (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    is_mem   = is_load || is_store;
    misal    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misal = (((op == OP_LH) || (op == OP_SH)) && (addr % 2 != 0)) ||
            (((op == OP_LW) || (op == OP_SW)) && (addr % 4 != 0));
`endif
    busy_cycles = (!is_mem || misal) ? 0 : ((waits + 1 < ACK_TIMEOUT) ? waits + 1 : ACK_TIMEOUT);
    exp_err     = is_mem && (misal || waits >= ACK_TIMEOUT);
    exp_stall   = is_mem ? 1 + busy_cycles : 0;

    b8  = byte'(rdata >> (8 * (addr % 4)));
    h16 = shortint'(rdata >> (16 * ((addr / 2) % 2)));
    if (op == OP_LB)      exp_ext = int'(b8);
    else if (op == OP_LH) exp_ext = int'(h16);
    else                  exp_ext = rdata;

    if (op == OP_LB || op == OP_SB)      exp_be = 4'(1 << (addr % 4));
    else if (op == OP_LH || op == OP_SH) exp_be = ((addr / 2) % 2 != 0) ? 4'hC : 4'h3;
    else                                 exp_be = 4'hF;

    if (op == OP_SB)      exp_bw = (r2 % 256) * 32'h01010101;
    else if (op == OP_SH) exp_bw = (r2 % 65536) * 32'h00010001;
    else                  exp_bw = r2;

    exp_wreg  = is_mem ? ((is_load && !exp_err) ? wen : 1'b0) : wen;
    exp_wdata = is_mem ? ((is_load && !exp_err) ? exp_ext : 32'h0) : wdat;

    @(negedge clk);
    aluop = op; mem_addr = addr; reg2 = r2; wdata = wdat; wd = wdst; wreg = wen;
    bus.data_rdata_i = rdata;
    bus.data_ack_i   = 1'b0;
    stall = 0; reqc = 0; errc = 0; cyc = 0; done = 1'b0;
    while (!done) begin
      #1;
      if (bus.data_req_o) begin
        reqc++;
        check("bus_addr", bus.data_addr_o, addr & 32'hFFFF_FFFC);
        check("bus_be", 32'(bus.data_be_o), 32'(exp_be));
        check("bus_we", 32'(bus.data_we_o), 32'(is_store));
        if (is_store) check("bus_wdata", bus.data_wdata_o, exp_bw);
        bus.data_ack_i = (reqc == waits + 1);
      end else begin
        bus.data_ack_i = 1'b0;
      end
      #1;
      if (stallreq) stall++;
      if (bus_err)  errc++;
      if (!stallreq) begin
        done = 1'b1;
        check("wd_o", 32'(wd_o), 32'(wdst));
        check("wreg_o", 32'(wreg_o), 32'(exp_wreg));
        check("wdata_o", wdata_o, exp_wdata);
      end else begin
        cyc++;
        if (cyc > 40) begin
          check("cycle_bound", cyc, 40);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    check("stall_cycles", stall, exp_stall);
    check("req_cycles", reqc, busy_cycles);
    check("err_pulses", errc, 32'(exp_err));
  endtask

  initial begin
    logic [7:0]  ops [7];
    logic [7:0]  op;
    int          r, waits;

    ops = '{OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW, OP_ORI};
    aluop = OP_ORI; mem_addr = 32'h1234_5677; reg2 = 32'hFFFF_FFFF;
    wdata = 32'hDEAD_BEEF; wd = 5'd5; wreg = 1'b1;
    bus.data_ack_i = 1'b0; bus.data_rdata_i = 32'h0;

    #12;
    check("rst_wd_o", 32'(wd_o), 32'h0);
    check("rst_wreg_o", 32'(wreg_o), 32'h0);
    check("rst_wdata_o", wdata_o, 32'h0);
    check("rst_stallreq", 32'(stallreq), 32'h0);
    check("rst_req", 32'(bus.data_req_o), 32'h0);
    check("rst_we", 32'(bus.data_we_o), 32'h0);
    check("rst_addr", bus.data_addr_o, 32'h0);
    check("rst_be", 32'(bus.data_be_o), 32'h0);
    check("rst_bwdata", bus.data_wdata_o, 32'h0);
    check("rst_err", 32'(bus_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    run_op(OP_ORI, 32'h0,      32'h0,        32'h0000_F00F, 32'h0,          5'd3, 1'b1, 0);
    run_op(OP_LB,  32'h1003,   32'h0,        32'h0,         32'h80FF_1234,  5'd4, 1'b1, 0);
    run_op(OP_SH,  32'h2002,   32'hAAAA_5678, 32'h0,        32'h0,          5'd6, 1'b1, 3);
    run_op(OP_LW,  32'h5000,   32'h0,        32'h0,         32'h1111_2222,  5'd7, 1'b1, 100);
    run_op(OP_LW,  32'h5004,   32'h0,        32'h0,         32'hCAFE_F00D,  5'd8, 1'b1, ACK_TIMEOUT - 1);
    run_op(OP_LW,  32'h3001,   32'h0,        32'h0,         32'h8765_4321,  5'd9, 1'b1, 0);
    run_op(OP_LH,  32'h3006,   32'h0,        32'h0,         32'h8001_7FFF,  5'd10, 1'b1, 1);

    // Asynchronous reset while the bus cycle is outstanding
    @(negedge clk);
    aluop = OP_LW; mem_addr = 32'h4000; wreg = 1'b1; bus.data_ack_i = 1'b0;
    @(negedge clk); #1;
    check("mid_req_up", 32'(bus.data_req_o), 32'h1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus.data_req_o), 32'h0);
    check("mid_rst_stall", 32'(stallreq), 32'h0);
    check("mid_rst_wreg", 32'(wreg_o), 32'h0);
    check("mid_rst_err", 32'(bus_err), 32'h0);
    aluop = OP_NOP; wdata = 32'h1234_5678; wd = 5'd7; wreg = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_stall", 32'(stallreq), 32'h0);
    check("post_rst_pass", wdata_o, 32'h1234_5678);
    check("post_rst_req", 32'(bus.data_req_o), 32'h0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 7);
      op = (r < 7) ? ops[r] : 8'($urandom_range(0, 8'hDF));
      r = $urandom_range(0, 9);
      waits = (r < 7) ? r : ((r == 7) ? ACK_TIMEOUT - 1 : ((r == 8) ? ACK_TIMEOUT : 30));
      run_op(op, $urandom, $urandom, $urandom, $urandom,
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), waits);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage consumer of the execute stage's outputs: aluop, mem_addr, reg2 (store data), wd/wreg/wdata.
- Passes non-memory results through to write-back.
- For LB/LH/LW/SB/SH/SW, runs a req/ack transaction on the data-memory bus, then sign-extends load data into the write-back value.
- Holds the pipeline with stallreq until each transaction completes.

Parameters:
- ACK_TIMEOUT, 16: maximum cycles in BUSY waiting for data_ack_i before the access is aborted.
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- aluop_i  in  8 (AluOpBus)  operation from execute stage
- mem_addr_i  in  32  effective byte address
- reg2_i  in  32  store data (low byte/half used for SB/SH)
- wd_i  in  5  destination register
- wreg_i  in  1  write enable
- wdata_i  in  32  execute-stage result
- wd_o  out  5  to write-back
- wreg_o  out  1  to write-back
- wdata_o  out  32  to write-back
- stallreq  out  1  stage stall request
- data_req_o  out  1  bus request
- data_we_o  out  1  1 = store
- data_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  lane-replicated store data
- data_ack_i  in  1  bus completion
- data_rdata_i  in  32  read data, valid with ack
- bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, load-data register=0.
  - data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0, bus_err_o=0.
  - wd_o=0, wreg_o=0, wdata_o=0, stallreq=0.
- Memory op: aluop_i is one of LB/LH/LW/SB/SH/SW. Any other aluop is non-memory.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Non-memory op: wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i (combinational), stallreq=0, stay IDLE.
  - Memory op: stallreq=1. Register addr, be, we and wdata onto the bus; next state BUSY.
- BUSY:
  - data_req_o=1; bus outputs held stable; stallreq=1; counter increments each cycle.
  - On data_ack_i=1: capture the extended load data, drop data_req_o, go to DONE.
  - If counter reaches ACK_TIMEOUT with no ack: drop data_req_o, pulse bus_err_o, go to DONE with the error flag set.
- DONE (exactly one cycle):
  - stallreq=0 and wd_o=wd_i.
  - wreg_o: wreg_i for a load without error; 0 for stores and on error.
  - wdata_o: captured load data for loads, 0 otherwise.
  - Next state IDLE; counter cleared.
- Pipeline contract: the upstream stage keeps all *_i inputs constant while stallreq=1.
- Latency: with ack in the first BUSY cycle, a memory op occupies the stage 3 cycles (IDLE, BUSY, DONE). Each extra wait cycle adds 1.
- Lanes are little-endian:
  - LB/SB: addr[1:0]=n gives be=1<<n; store data replicated to all four bytes.
  - LH/SH: addr[1]=0 gives be=0011, addr[1]=1 gives be=1100; store data replicated to both halves.
  - LW/SW: be=1111.
- Load extension: LB sign-extends the selected byte; LH sign-extends the selected half; LW passes the full word.
- data_ack_i in IDLE or DONE is ignored. Ack arriving in the same cycle as the timeout is treated as success; no error.
- Reset asserted in BUSY: request drops immediately with no error pulse, and the transaction is lost.
- Back-to-back memory ops: DONE→IDLE, then the new op issues its request the following cycle.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: LH/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, skip BUSY.
  - IDLE goes straight to DONE with the error flag set; no bus request.
  - bus_err_o pulses in the IDLE cycle; wreg_o=0 in DONE.
- Undefined: low address bits are ignored for alignment; the access is issued with the lane rules above (LW always be=1111).

Test Plan:
- Non-memory op: ORI result wdata_i=0x0000F00F, wd_i=3, wreg_i=1 → same cycle wdata_o=0x0000F00F, wd_o=3, wreg_o=1; stallreq=0, data_req_o never asserted.
- LB: addr 0x1003, rdata=0x80FF1234, ack on the 1st BUSY cycle → data_addr_o=0x1000, be=1000, stallreq high 2 cycles, DONE wdata_o=0xFFFFFF80, wreg_o=1.
- SH: addr 0x2002, reg2_i=0xAAAA5678, ack after 3 wait cycles → data_we_o=1, be=1100, data_wdata_o=0x56785678, stallreq high 5 cycles, wreg_o=0 in DONE.
- Timeout: LW with data_ack_i held 0 → req high exactly ACK_TIMEOUT cycles, bus_err_o single pulse, wreg_o=0 in DONE, then IDLE.
- Reset mid-BUSY: rst=0 asynchronously during BUSY → data_req_o, stallreq, wreg_o drop immediately with no bus_err_o pulse; after release, state is IDLE.
- With MEM_ALIGN_CHECK_EN: LW at 0x3001 → no data_req_o, bus_err_o pulse, stallreq 1 cycle, wreg_o=0.
- Without MEM_ALIGN_CHECK_EN: LW at 0x3001 → request to 0x3000 with be=1111.
